// File: rtl/spi_pwm_cmd_master.sv
// SPI mode-0 initiator: serialises channel/level commands into 16-bit frames for the
// PWM driver's slave port and returns the word shifted in on miso during each frame.
module spi_pwm_cmd_master #(
   parameter int unsigned HALF = 4,
   parameter int unsigned GAP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_chan,
   input  logic [7:0]  cmd_level,
   output logic        sclk,
   output logic        cs,
   output logic        mosi,
   input  logic        miso,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        busy
);

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned IDX_W   = 4;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);
   localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   phase_cnt;
   logic [CNT_W-1:0]   phase_cnt_nxt;
   logic [IDX_W-1:0]   bit_idx;
   logic [IDX_W-1:0]   bit_idx_nxt;
   logic               last_bit;
   logic               last_bit_nxt;
   logic [FRAME_W-1:0] word;
   logic [FRAME_W-1:0] word_nxt;
   logic [FRAME_W-1:0] rx_shift;
   logic [FRAME_W-1:0] rx_shift_nxt;
   logic [FRAME_W-1:0] rx_data_nxt;
   logic               sclk_nxt;
   logic               cs_nxt;
   logic               mosi_nxt;
   logic               rx_valid_nxt;
   logic               busy_nxt;
   logic               handshake;
   logic               phase_done;

   assign cmd_ready  = (state == S_IDLE) && !reset;
   assign handshake  = cmd_valid && cmd_ready;
   assign phase_done = (phase_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: every timed state advances when its phase counter reaches zero
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (handshake)  state_nxt = S_SETUP;
         S_SETUP: if (phase_done) state_nxt = S_HIGH;
         S_HIGH:  if (phase_done) state_nxt = S_LOW;
         S_LOW:   if (phase_done) state_nxt = last_bit ? S_GAP : S_HIGH;
         S_GAP:   if (phase_done) state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; edge actions happen on the transition into each state
   always_comb begin
      phase_cnt_nxt = phase_done ? phase_cnt : phase_cnt - CNT_W'(1);
      bit_idx_nxt   = bit_idx;
      last_bit_nxt  = last_bit;
      word_nxt      = word;
      rx_shift_nxt  = rx_shift;
      rx_data_nxt   = rx_data;
      sclk_nxt      = sclk;
      cs_nxt        = cs;
      mosi_nxt      = mosi;
      rx_valid_nxt  = 1'b0;
      busy_nxt      = busy;
      case (state)
         S_IDLE: begin
            if (handshake) begin
               word_nxt      = {5'b00000, cmd_chan, cmd_level};
               mosi_nxt      = word_nxt[FRAME_W-1];
               cs_nxt        = 1'b0;
               sclk_nxt      = 1'b0;
               busy_nxt      = 1'b1;
               bit_idx_nxt   = IDX_MSB;
               last_bit_nxt  = 1'b0;
               rx_shift_nxt  = '0;
               phase_cnt_nxt = HALF_LOAD;
            end
         end
         S_SETUP: begin
            if (phase_done) begin
               sclk_nxt      = 1'b1;
               rx_shift_nxt  = {rx_shift[FRAME_W-2:0], miso};
               phase_cnt_nxt = HALF_LOAD;
            end
         end
         S_HIGH: begin
            if (phase_done) begin
               sclk_nxt      = 1'b0;
               phase_cnt_nxt = HALF_LOAD;
               if (bit_idx != '0) begin
                  bit_idx_nxt = bit_idx - IDX_W'(1);
                  mosi_nxt    = word[bit_idx_nxt];
               end else begin
                  last_bit_nxt = 1'b1;
               end
            end
         end
         S_LOW: begin
            if (phase_done) begin
               if (last_bit) begin
                  cs_nxt        = 1'b1;
                  mosi_nxt      = 1'b0;
                  rx_data_nxt   = rx_shift;
                  rx_valid_nxt  = 1'b1;
                  phase_cnt_nxt = GAP_LOAD;
               end else begin
                  sclk_nxt      = 1'b1;
                  rx_shift_nxt  = {rx_shift[FRAME_W-2:0], miso};
                  phase_cnt_nxt = HALF_LOAD;
               end
            end
         end
         S_GAP: begin
            if (phase_done) busy_nxt = 1'b0;
         end
         default: begin
            cs_nxt   = 1'b1;
            sclk_nxt = 1'b0;
            mosi_nxt = 1'b0;
            busy_nxt = 1'b0;
         end
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_cnt <= '0;
         bit_idx   <= '0;
         last_bit  <= 1'b0;
         word      <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         sclk      <= 1'b0;
         cs        <= 1'b1;
         mosi      <= 1'b0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         phase_cnt <= phase_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         last_bit  <= last_bit_nxt;
         word      <= word_nxt;
         rx_shift  <= rx_shift_nxt;
         rx_data   <= rx_data_nxt;
         sclk      <= sclk_nxt;
         cs        <= cs_nxt;
         mosi      <= mosi_nxt;
         rx_valid  <= rx_valid_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: doc/spi_pwm_cmd_master.md
Name: spi_pwm_cmd_master

Overview:
SPI initiator that drives the 7-channel PWM driver's SPI slave port (sclk, cs, mosi, miso) from a parallel command interface.
- Accepts a channel/level command over a valid/ready handshake and serialises it as one 16-bit frame.
- Generates sclk slowly enough for a slave that oversamples sclk with its own system clock.
- Captures miso in parallel and returns it as a 16-bit read word.

Parameters:
HALF, 4, clk cycles per sclk phase (high or low); legal range 1..255. The slave requires HALF >= 2 of its own clocks.
GAP, 4, clk cycles cs is held high between frames; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command this cycle
cmd_chan  input  3  PWM channel index 0..7 (7 is sent unchecked)
cmd_level  input  8  PWM level
sclk  output  1  SPI clock, idle low (mode 0)
cs  output  1  chip select, active low, idle high
mosi  output  1  serial data out, MSB first
miso  input  1  serial data in
rx_data  output  16  bits captured from miso during the last frame, first bit in [15]
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  high while a frame or the inter-frame gap is in progress

Behaviour:
- Single clock domain. All outputs are registered except cmd_ready.
- cmd_ready = (state == IDLE) && !reset.
- Reset, synchronous, overrides everything, including mid-frame:
  - state=IDLE, cs=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, busy=0.
  - Shift and phase counters are cleared. No partial frame resumes.
  - cs rises on the clock edge where reset is sampled.
- Frame word: {5'b00000, cmd_chan, cmd_level}, latched on the handshake (cmd_valid && cmd_ready).
- States:
  - IDLE: on handshake, latch word, cs<=0, mosi<=word[15], sclk<=0, busy<=1, go to SETUP.
  - SETUP: hold for HALF cycles, sclk low, then sclk<=1 and go to HIGH. Bit index = 15.
  - HIGH: on entry (the rising edge), sample miso into rx_shift LSB (shift left). Hold HALF cycles, then sclk<=0 and go to LOW.
  - LOW: on entry (the falling edge), if bit index > 0, decrement it and drive the next bit onto mosi. Hold HALF cycles.
    - If the bit just completed was bit 0, go to GAP and set cs<=1. This last LOW phase is the hold time.
    - Otherwise sclk<=1 and go to HIGH.
  - GAP: on entry, rx_data<=rx_shift and rx_valid<=1 for exactly that cycle. mosi<=0, cs=1. Hold GAP cycles, then busy<=0 and go to IDLE.
- Timing with HALF=h, GAP=g:
  - Handshake at cycle 0; cs falls at cycle 1.
  - First sclk rise at cycle 1+h.
  - 16 rising edges spaced 2h apart.
  - cs rises at cycle 1+33h.
  - cmd_ready high again at cycle 1+33h+g.
  - Default: 137 cycles handshake-to-ready.
- mosi is stable for the full HIGH phase and changes only on sclk falling edges, or on frame start.
- The phase counter is 8-bit, loads HALF-1 or GAP-1 on state entry, and counts down to 0.
- cmd_valid during busy is ignored; the command waits for cmd_ready.
- A command held valid across frames is accepted in the first IDLE cycle, giving back-to-back frames with exactly GAP cycles of cs high.
- cmd_chan and cmd_level changes after the handshake have no effect on the frame in flight.
- miso is sampled only on rising-edge cycles. miso is ignored in IDLE, SETUP and GAP.

Test Plan:
1. Reset held 3 cycles, then released → cs=1, sclk=0, mosi=0, busy=0, rx_valid=0; cmd_ready=1 on the first non-reset cycle.
2. HALF=4, GAP=4; cmd_chan=3, cmd_level=0xA5 → mosi sampled on the 16 sclk rises reads 0x03A5. cs low for exactly 132 cycles; cmd_ready returns 137 cycles after the handshake.
3. miso driven from a shift register preloaded with 0xBEEF, updating on sclk falls (first bit valid before the first rise) → rx_data=0xBEEF with a single-cycle rx_valid as cs rises.
4. cmd_valid held high with (1,0x10) then (6,0xFF) → two frames 0x0110 and 0x06FF; cs high for exactly GAP=4 cycles between them. The second command's values, if changed mid-frame, do not corrupt the first frame.
5. Reset asserted after the 8th sclk rise → next cycle cs=1, sclk=0, mosi=0, rx_valid never pulses. A new command then sends a full clean 16-bit frame.
6. HALF=1, GAP=1; cmd_chan=7, cmd_level=0x00 → frame 0x0700. sclk toggles every cycle; handshake-to-ready is 35 cycles.
